// File: rtl/noc_output_arbiter.sv
// rtl/noc_output_arbiter.sv - round-robin, packet-locked arbiter for one router output port
//
// Shares one output link among N_IN input-channel FIFOs. A granted channel
// keeps the port until its tail flit is transferred; arbitration then reopens
// from the channel after the previous owner.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   req        per-channel: head flit present and routed to this port
//   empty      per-channel FIFO empty flag
//   tail       per-channel: current head flit is a tail flit
//   data_in    per-channel head flits, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   down_full  downstream buffer full, blocks any transfer
//   read       one-hot FIFO read strobe
//   data_out   flit to the output link (zero when not valid)
//   out_valid  data_out is transferred this cycle
//   grant_id   index of the current (or most recent) owner
//   busy       port is locked to an owner
module noc_output_arbiter #(
    parameter int N_IN       = 5,
    parameter int DATA_WIDTH = 8,
    parameter int ID_W       = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_IN-1:0]            req,
    input  logic [N_IN-1:0]            empty,
    input  logic [N_IN-1:0]            tail,
    input  logic [N_IN*DATA_WIDTH-1:0] data_in,
    input  logic                       down_full,
    output logic [N_IN-1:0]            read,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       out_valid,
    output logic [ID_W-1:0]            grant_id,
    output logic                       busy
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ID_W-1:0]       r_grant_id;
    logic [ID_W-1:0]       w_grant_nxt;
    logic [ID_W-1:0]       r_rr_ptr;
    logic [ID_W-1:0]       w_rr_nxt;
    logic [ID_W-1:0]       w_pick;
    logic                  w_found;
    logic                  w_sel_empty;
    logic                  w_sel_tail;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_xfer;

    // Cyclic scan from r_rr_ptr done as two linear passes: the first pass only
    // accepts channels at or above the pointer; if none, the second pass takes
    // the lowest requester, which is necessarily below the pointer.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (!w_found && req[i] && (ID_W'(i) >= r_rr_ptr)) begin
                w_found = 1'b1;
                w_pick  = ID_W'(i);
            end
        end
        for (int i = 0; i < N_IN; i++) begin
            if (!w_found && req[i]) begin
                w_found = 1'b1;
                w_pick  = ID_W'(i);
            end
        end
    end

    // Owner's FIFO status and head flit.
    always_comb begin
        w_sel_empty = 1'b1;
        w_sel_tail  = 1'b0;
        w_sel_data  = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (ID_W'(i) == r_grant_id) begin
                w_sel_empty = empty[i];
                w_sel_tail  = tail[i];
                w_sel_data  = data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_xfer = (r_state == S_LOCKED) && !w_sel_empty && !down_full;

    always_comb begin
        read = '0;
        for (int i = 0; i < N_IN; i++) begin
            read[i] = w_xfer && (ID_W'(i) == r_grant_id);
        end
        out_valid = w_xfer;
        data_out  = w_xfer ? w_sel_data : '0;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant_id;
        w_rr_nxt    = r_rr_ptr;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_LOCKED;
                    w_grant_nxt = w_pick;
                end
            end
            S_LOCKED: begin
                // req is deliberately ignored here: the lock lasts until the tail.
                if (w_xfer && w_sel_tail) begin
                    w_state_nxt = S_IDLE;
                    w_rr_nxt    = (r_grant_id == ID_W'(N_IN - 1)) ? '0
                                                                  : r_grant_id + ID_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant_id <= w_grant_nxt;
            r_rr_ptr   <= w_rr_nxt;
        end
    end

    assign busy     = (r_state == S_LOCKED);
    assign grant_id = r_grant_id;

    a_read_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(read));
    a_no_read_full: assert property (@(posedge clk) disable iff (rst) down_full |-> (read == '0));
    a_no_read_empty: assert property (@(posedge clk) disable iff (rst) (read & empty) == '0);
    a_grant_range: assert property (@(posedge clk) disable iff (rst) int'(grant_id) < N_IN);

endmodule

// File: tb/tb_noc_output_arbiter.sv
// tb/tb_noc_output_arbiter.sv - directed and randomized checks of noc_output_arbiter against a packet-level model
module tb_noc_output_arbiter;

    localparam int N  = 5;
    localparam int W  = 8;
    localparam int IW = 3;

    typedef struct {
        logic [W-1:0] d;
        bit           h;
        bit           t;
    } flit_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N-1:0]   empty;
    logic [N-1:0]   tail;
    logic [N*W-1:0] data_in;
    logic           down_full;
    logic [N-1:0]   read;
    logic [W-1:0]   data_out;
    logic           out_valid;
    logic [IW-1:0]  grant_id;
    logic           busy;

    int n_checks = 0;
    int n_pass   = 0;

    flit_t q[N][$];
    int    owner;
    int    ptr;
    int    gid;

    noc_output_arbiter #(.N_IN(N), .DATA_WIDTH(W), .ID_W(IW)) dut (
        .clk(clk), .rst(rst), .req(req), .empty(empty), .tail(tail),
        .data_in(data_in), .down_full(down_full), .read(read),
        .data_out(data_out), .out_valid(out_valid), .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_outputs(input string tag, input logic [N-1:0] e_read,
                                 input logic [W-1:0] e_data, input logic e_busy,
                                 input logic [IW-1:0] e_gid);
        check({tag, "_read"}, read, e_read);
        check({tag, "_valid"}, out_valid, (e_read != 0));
        check({tag, "_data"}, data_out, e_data);
        check({tag, "_busy"}, busy, e_busy);
        check({tag, "_gid"}, grant_id, e_gid);
    endtask

    initial begin
        logic [N-1:0] e_read;
        logic [W-1:0] e_data;
        int           pick;
        bit           last;

        rst = 1'b1; req = '0; empty = '1; tail = '0; data_in = '0; down_full = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check_outputs("reset", '0, '0, 1'b0, '0);

        // Single-flit packet on channel 2.
        @(negedge clk);
        rst = 1'b0; empty = '0; req = 5'b00100; tail = 5'b00100;
        data_in[2*W +: W] = 8'hA5;
        #1 check("idle_no_read", read, '0);
        @(posedge clk); #1;
        check_outputs("single", 5'b00100, 8'hA5, 1'b1, 3'd2);
        @(negedge clk); req = '0;
        @(posedge clk); #1;
        check_outputs("single_done", '0, '0, 1'b0, 3'd2);

        // rr_ptr is now 3: channel 3 must beat channel 0.
        @(negedge clk); req = 5'b01001; tail = 5'b01000; data_in[3*W +: W] = 8'h3C;
        @(posedge clk); #1;
        check_outputs("ptr3", 5'b01000, 8'h3C, 1'b1, 3'd3);
        @(negedge clk); req = '0;
        @(posedge clk);

        // rr_ptr is now 4: channel 4 first, then wrap to channel 0.
        @(negedge clk); req = 5'b10001; tail = 5'b10001;
        data_in[4*W +: W] = 8'h44; data_in[0 +: W] = 8'h11;
        @(posedge clk); #1;
        check_outputs("wrap_first", 5'b10000, 8'h44, 1'b1, 3'd4);
        @(posedge clk); #1;
        check_outputs("bubble", '0, '0, 1'b0, 3'd4);
        @(posedge clk); #1;
        check_outputs("wrap_second", 5'b00001, 8'h11, 1'b1, 3'd0);
        @(negedge clk); req = '0;
        @(posedge clk);

        // Asynchronous reset mid-packet on channel 2 (rr_ptr is 1 here).
        @(negedge clk); req = 5'b00100; tail = '0; data_in[2*W +: W] = 8'h77;
        @(posedge clk); #1;
        check_outputs("pre_rst", 5'b00100, 8'h77, 1'b1, 3'd2);
        #2 rst = 1'b1;
        #1 check_outputs("async_rst", '0, '0, 1'b0, 3'd0);
        @(negedge clk); rst = 1'b0; req = 5'b00101; tail = 5'b00101;
        @(posedge clk); #1;
        check("post_rst_gid", grant_id, 3'd0);
        @(negedge clk); rst = 1'b1; req = '0;
        @(posedge clk);
        @(negedge clk); rst = 1'b0;

        // Randomized traffic against a packet-level model.
        owner = -1; ptr = 0; gid = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (q[i].size() == 0 && $urandom_range(0, 3) == 0) begin
                    int len;
                    len = $urandom_range(1, 4);
                    for (int k = 0; k < len; k++) begin
                        flit_t f;
                        f.d = W'($urandom);
                        f.h = (k == 0);
                        f.t = (k == len - 1);
                        q[i].push_back(f);
                    end
                end
            end
            down_full = ($urandom_range(0, 4) == 0);
            for (int i = 0; i < N; i++) begin
                empty[i] = (q[i].size() == 0) || ($urandom_range(0, 5) == 0);
                req[i]   = !empty[i] && q[i][0].h;
                tail[i]  = !empty[i] && q[i][0].t;
                data_in[i*W +: W] = (q[i].size() != 0) ? q[i][0].d : W'($urandom);
            end
            #1;
            e_read = '0;
            e_data = '0;
            check("rnd_busy", busy, owner >= 0);
            check("rnd_gid", grant_id, gid);
            if (owner < 0) begin
                pick = -1;
                for (int k = 0; k < N; k++) begin
                    if (pick < 0 && req[(ptr + k) % N]) pick = (ptr + k) % N;
                end
                if (pick >= 0) begin
                    owner = pick;
                    gid   = pick;
                end
            end else if (!empty[owner] && !down_full) begin
                e_read = N'(1) << owner;
                e_data = q[owner][0].d;
                last   = q[owner][0].t;
                void'(q[owner].pop_front());
                if (last) begin
                    ptr   = (owner + 1) % N;
                    owner = -1;
                end
            end
            check("rnd_read", read, e_read);
            check("rnd_valid", out_valid, e_read != 0);
            check("rnd_data", data_out, e_data);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
